// File: rtl/spi_tgt_pkg.sv
// Shared definitions for the SPI target bridge.
//   CMD_WRITE / CMD_READ : recognised command bytes
//   state_t              : frame-level FSM states
//   cmd_known()          : true for a command byte that opens a register access
package spi_tgt_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_WRITE) || (c == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_tgt_sync.sv
// Brings the SPI pad inputs into the HCLK domain and finds SCLK/SSn edges.
//   HCLK, HRESETn : system clock, async active-low reset
//   sclk_i/ssn_i/mosi_i : raw SPI pad inputs
//   sclk_rise/sclk_fall : registered edge pulses (one cycle after detection)
//   ssn_s, mosi_s       : synchronized select / data
//   ssn_fall            : select assertion, only after the chain holds real samples
module spi_tgt_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic sclk_i,
  input  logic ssn_i,
  input  logic mosi_i,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ssn_s,
  output logic ssn_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_ff, ssn_ff, mosi_ff, prime;
  logic sclk_s, sclk_q, ssn_q;

  assign sclk_s = sclk_ff[SYNC_STAGES-1];
  assign ssn_s  = ssn_ff[SYNC_STAGES-1];
  assign mosi_s = mosi_ff[SYNC_STAGES-1];

  // ssn_q stays 0 until the chain has flushed its reset contents, so a
  // select that was already low when reset released is not taken as a fall:
  // a frame only starts on a genuine high-to-low transition.
  assign ssn_fall = ssn_q & ~ssn_s;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sclk_ff   <= '0;
      ssn_ff    <= '1;
      mosi_ff   <= '0;
      prime     <= '0;
      sclk_q    <= 1'b0;
      ssn_q     <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk_i};
      ssn_ff    <= {ssn_ff[SYNC_STAGES-2:0], ssn_i};
      mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], mosi_i};
      prime     <= {prime[SYNC_STAGES-2:0], 1'b1};
      sclk_q    <= sclk_s;
      ssn_q     <= prime[SYNC_STAGES-1] & ssn_s;
      sclk_rise <= sclk_s & ~sclk_q;
      sclk_fall <= ~sclk_s & sclk_q;
    end
  end

endmodule

// File: rtl/spi_target_bridge.sv
// SPI mode-0 target giving an external master byte access to a register space.
// Frame: cmd, addr, [dummy if read], data... until SSn rises; address auto-increments.
//   HCLK, HRESETn          : system clock, async active-low reset
//   sclk_i, ssn_i, mosi_i  : SPI inputs (oversampled, SCLK <= HCLK/8)
//   miso_o, miso_oeb       : SPI data out and active-low pad enable
//   addr_o, wr_en_o, wr_data_o, rd_en_o, rd_data_i : register port
//   busy_o                 : frame in progress (select low)
//   cmd_err_o              : pulse on an unrecognised command byte
module spi_target_bridge
  import spi_tgt_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              sclk_i,
  input  logic              ssn_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oeb,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wr_en_o,
  output logic [7:0]        wr_data_o,
  output logic              rd_en_o,
  input  logic [7:0]        rd_data_i,
  output logic              busy_o,
  output logic              cmd_err_o
);

  logic sclk_rise, sclk_fall, ssn_s, ssn_fall, mosi_s;

  spi_tgt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sclk_i    (sclk_i),
    .ssn_i     (ssn_i),
    .mosi_i    (mosi_i),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ssn_s     (ssn_s),
    .ssn_fall  (ssn_fall),
    .mosi_s    (mosi_s)
  );

  state_t      state, state_n;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  rx_byte, shift_out;
  logic        is_rd, rd_cap;
  logic        sel, rise_v, fall_v, byte_done;

  // Edges outside a selected frame are ignored; deselect outranks byte_done.
  assign sel       = ~ssn_s;
  assign rise_v    = sclk_rise & sel;
  assign fall_v    = sclk_fall & sel;
  assign byte_done = rise_v & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, mosi_s};

  assign busy_o   = sel;
  assign miso_oeb = ~(sel && (state == ST_DUMMY || state == ST_RDATA));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (ssn_s) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (ssn_fall)  state_n = ST_CMD;
        ST_CMD:   if (byte_done) state_n = cmd_known(rx_byte) ? ST_ADDR : ST_IGNORE;
        ST_ADDR:  if (byte_done) state_n = is_rd ? ST_DUMMY : ST_WDATA;
        ST_DUMMY: if (byte_done) state_n = ST_RDATA;
        default:  state_n = state;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      miso_o    <= 1'b0;
      addr_o    <= '0;
      wr_en_o   <= 1'b0;
      wr_data_o <= 8'h00;
      rd_en_o   <= 1'b0;
      cmd_err_o <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_sr     <= 7'd0;
      shift_out <= 8'h00;
      is_rd     <= 1'b0;
      rd_cap    <= 1'b0;
    end else begin
      wr_en_o   <= 1'b0;
      rd_en_o   <= 1'b0;
      cmd_err_o <= 1'b0;
      rd_cap    <= rd_en_o;
      // Write address advances the cycle after the strobe it belonged to.
      if (wr_en_o) addr_o <= addr_o + ADDR_W'(1);
      if (ssn_s) begin
        bit_cnt <= 3'd0;
        miso_o  <= 1'b0;
      end else begin
        if (rise_v) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          ST_CMD: if (byte_done) begin
            is_rd     <= (rx_byte == CMD_READ);
            cmd_err_o <= ~cmd_known(rx_byte);
          end
          // The read strobe for the first location appears together with the
          // new address, on the first DUMMY cycle.
          ST_ADDR: if (byte_done) begin
            addr_o  <= rx_byte[ADDR_W-1:0];
            rd_en_o <= is_rd;
          end
          ST_DUMMY: miso_o <= 1'b0;
          ST_WDATA: if (byte_done) begin
            wr_data_o <= rx_byte;
            wr_en_o   <= 1'b1;
          end
          ST_RDATA: begin
            if (fall_v) begin
              miso_o    <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
            end
            if (byte_done) begin
              addr_o  <= addr_o + ADDR_W'(1);
              rd_en_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // Read data lands well before the next SCLK fall; placed last so a
      // load always wins over a shift.
      if (rd_cap) shift_out <= rd_data_i;
    end
  end

endmodule

// File: tb/tb_spi_target_bridge.sv
// Bench for spi_target_bridge: a mode-0 SPI master model (SCLK = HCLK/8)
// drives frames; a frame-level reference model predicts write/read strobes,
// MISO bytes, error pulses and the final address.
module tb_spi_target_bridge;

  logic       HCLK = 1'b0, HRESETn = 1'b0;
  logic       sclk_i = 1'b0, ssn_i = 1'b1, mosi_i = 1'b0;
  logic       miso_o, miso_oeb, wr_en_o, rd_en_o, busy_o, cmd_err_o;
  logic [7:0] addr_o, wr_data_o;
  logic [7:0] rd_data_i = 8'h00;

  always #5 HCLK = ~HCLK;

  spi_target_bridge #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .sclk_i(sclk_i), .ssn_i(ssn_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oeb(miso_oeb), .addr_o(addr_o), .wr_en_o(wr_en_o),
    .wr_data_o(wr_data_o), .rd_en_o(rd_en_o), .rd_data_i(rd_data_i),
    .busy_o(busy_o), .cmd_err_o(cmd_err_o)
  );

  // Register space behind the bridge: data one cycle after the read strobe.
  logic [7:0] mem [256];
  always @(posedge HCLK) if (rd_en_o) rd_data_i <= mem[addr_o];

  // Strobe monitor.
  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  int n_err = 0, n_oeb_low = 0;
  always @(negedge HCLK) begin
    if (wr_en_o)   wq.push_back({addr_o, wr_data_o});
    if (rd_en_o)   rq.push_back(addr_o);
    if (cmd_err_o) n_err++;
    if (!miso_oeb) n_oeb_low++;
  end

  int ncmp = 0, nfail = 0;
  logic [7:0] exp_addr;
  logic [7:0] txb[$], rxb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge HCLK);
  endtask

  // One (possibly partial) byte, MSB first; MISO sampled at each SCLK rise.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 7; b >= 8 - nbits; b--) begin
      mosi_i = tx[b];
      half();
      rx = {rx[6:0], miso_o};
      sclk_i = 1'b1;
      half();
      sclk_i = 1'b0;
    end
  endtask

  task automatic run_frame(input int last_bits);
    logic [7:0] r;
    rxb.delete();
    ssn_i = 1'b0;
    for (int i = 0; i < txb.size(); i++) begin
      xfer(txb[i], (i == txb.size() - 1) ? last_bits : 8, r);
      rxb.push_back(r);
    end
    half();
    ssn_i = 1'b1;
    repeat (12) @(negedge HCLK);
  endtask

  // Reference: writes land at addr, addr+1, ...; reads fetch addr (on the
  // dummy byte) and one further location after every completed data byte.
  task automatic do_frame(input string nm, input int last_bits);
    int wb, rb, eb, ob, full, nd, ee;
    logic [7:0] cmd, a;
    logic [15:0] ew[$];
    logic [7:0]  er[$];
    bit rd_frame;
    wb = wq.size(); rb = rq.size(); eb = n_err; ob = n_oeb_low;
    run_frame(last_bits);
    full = (last_bits < 8) ? txb.size() - 1 : txb.size();
    cmd = txb[0]; ee = 0; rd_frame = 0; nd = 0;
    if (full >= 1 && cmd != 8'h02 && cmd != 8'h03) ee = 1;
    if ((cmd == 8'h02 || cmd == 8'h03) && full >= 2) begin
      a = txb[1];
      if (cmd == 8'h02) begin
        for (int i = 2; i < full; i++) ew.push_back({8'(a + i - 2), txb[i]});
        exp_addr = 8'(a + full - 2);
      end else begin
        rd_frame = 1;
        nd = (full >= 3) ? full - 3 : 0;
        for (int k = 0; k <= nd; k++) er.push_back(8'(a + k));
        exp_addr = 8'(a + nd);
        if (full >= 3) check($sformatf("%s_dummy", nm), rxb[2], 8'h00);
        for (int i = 3; i < full; i++)
          check($sformatf("%s_miso%0d", nm, i - 3), rxb[i], mem[8'(a + i - 3)]);
      end
    end
    check($sformatf("%s_nwr", nm), wq.size() - wb, ew.size());
    for (int i = 0; i < ew.size() && wb + i < wq.size(); i++)
      check($sformatf("%s_wr%0d", nm, i), wq[wb + i], ew[i]);
    check($sformatf("%s_nrd", nm), rq.size() - rb, er.size());
    for (int i = 0; i < er.size() && rb + i < rq.size(); i++)
      check($sformatf("%s_rd%0d", nm, i), rq[rb + i], er[i]);
    check($sformatf("%s_err", nm), n_err - eb, ee);
    check($sformatf("%s_oeb", nm), 32'(n_oeb_low > ob), 32'(rd_frame));
    check($sformatf("%s_addr", nm), addr_o, exp_addr);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_miso"},  miso_o,    1'b0);
    check({nm, "_oeb"},   miso_oeb,  1'b1);
    check({nm, "_addr"},  addr_o,    8'h00);
    check({nm, "_wren"},  wr_en_o,   1'b0);
    check({nm, "_wdata"}, wr_data_o, 8'h00);
    check({nm, "_rden"},  rd_en_o,   1'b0);
    check({nm, "_busy"},  busy_o,    1'b0);
    check({nm, "_err"},   cmd_err_o, 1'b0);
  endtask

  initial begin
    logic [7:0] r;
    int wb, rb, eb, n, sel, lb;
    logic [7:0] c;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h20] = 8'h3C; mem[8'h21] = 8'hC3;

    repeat (3) @(negedge HCLK);
    check_reset_vals("rst");
    HRESETn = 1'b1;
    repeat (5) @(negedge HCLK);
    exp_addr = 8'h00;

    txb = '{8'h02, 8'h10, 8'hA5, 8'h5A};        do_frame("write2", 8);
    txb = '{8'h03, 8'h20, 8'h00, 8'h00, 8'h00}; do_frame("read2", 8);
    txb = '{8'h03, 8'hFF, 8'h00, 8'h00, 8'h00}; do_frame("readwrap", 8);
    txb = '{8'h9F, 8'h12, 8'h34, 8'h56};        do_frame("badcmd", 8);
    txb = '{8'h02, 8'h40, 8'hE3};               do_frame("partial", 5);
    txb = '{8'h02, 8'h41, 8'h77};               do_frame("after_partial", 8);

    // Reset in the middle of a read data byte.
    ssn_i = 1'b0;
    xfer(8'h03, 8, r); xfer(8'h50, 8, r); xfer(8'h00, 8, r); xfer(8'h00, 3, r);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    wb = wq.size(); rb = rq.size(); eb = n_err;
    xfer(8'hFF, 5, r);
    half();
    ssn_i = 1'b1;
    repeat (12) @(negedge HCLK);
    check("midrst_nwr", wq.size() - wb, 0);
    check("midrst_nrd", rq.size() - rb, 0);
    check("midrst_nerr", n_err - eb, 0);
    exp_addr = 8'h00;
    txb = '{8'h02, 8'h00, 8'h11}; do_frame("post_rst", 8);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      sel = $urandom_range(0, 2);
      c = (sel == 0) ? 8'h02 : (sel == 1) ? 8'h03 : 8'($urandom_range(4, 255));
      n = $urandom_range(1, 4);
      txb.delete();
      txb.push_back(c);
      txb.push_back(8'($urandom));
      if (c == 8'h03) txb.push_back(8'($urandom));
      for (int i = 0; i < n; i++) txb.push_back(8'($urandom));
      lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      do_frame($sformatf("rnd%0d", f), lb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
